// File: rtl/fifo_read_ctrl.sv
//------------------------------------------------------------------------------
// fifo_read_ctrl: read-domain side of the asynchronous FIFO.
// Synchronizes the write pointer, keeps the read pointer, and feeds a valid/ready stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_read_ctrl #(
    parameter int DEPTH       = 512,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 9,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   wptr_gray_async,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH:0]   binary_rptr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  r_en,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  almost_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wq_gray;
    logic [PW-1:0] wbin_sync;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] count_next;
    logic          pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_gray = sync_q[SYNC_STAGES-1];

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    for (genvar i = 0; i < PW; i++) begin : g_g2b
        assign wbin_sync[i] = ^wq_gray[PW-1:i];
    end

    // The output stage is refilled whenever it is empty or being drained.
    assign pop        = !empty && (!m_valid || m_ready);
    assign r_en       = pop;
    assign rbin_next  = binary_rptr + PW'(pop);
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    assign count_next = wbin_sync - rbin_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            binary_rptr  <= '0;
            rptr_gray    <= '0;
            empty        <= 1'b1;
            rd_count     <= '0;
            almost_empty <= 1'b1;
        end else begin
            binary_rptr  <= rbin_next;
            rptr_gray    <= rgray_next;
            empty        <= (rgray_next == wq_gray);
            rd_count     <= count_next;
            almost_empty <= (count_next <= PW'(AE_THRESH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (pop) begin
            m_valid <= 1'b1;
            m_data  <= mem_rdata;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
//------------------------------------------------------------------------------
// tb_fifo_read_ctrl: directed scoreboard bench for fifo_read_ctrl (DEPTH=8).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_read_ctrl;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] wptr_gray_async = '0;
    logic [DW-1:0] mem_rdata;
    logic [PW-1:0] binary_rptr;
    logic [PW-1:0] rptr_gray;
    logic          r_en;
    logic          empty;
    logic [PW-1:0] rd_count;
    logic          almost_empty;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_d;
    logic [PW-1:0] wbin = '0;
    logic [PW-1:0] prev_rptr = '0;
    int            wraps = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    int            sent;

    fifo_read_ctrl #(
        .DEPTH       (DEPTH),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (2),
        .AE_THRESH   (AE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wptr_gray_async (wptr_gray_async),
        .mem_rdata       (mem_rdata),
        .binary_rptr     (binary_rptr),
        .rptr_gray       (rptr_gray),
        .r_en            (r_en),
        .empty           (empty),
        .rd_count        (rd_count),
        .almost_empty    (almost_empty),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[binary_rptr[AW-1:0]];

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wbin[AW-1:0]] = d;
        wbin = wbin + 1'b1;
        wptr_gray_async = gray(wbin);
        sb.push_back(d);
    endtask

    // One clock: handshake checked at the falling edge, pointer checks just after the rising edge.
    task automatic step();
        @(negedge clk);
        check("r_en", 32'(r_en), 32'(!empty && (!m_valid || m_ready)));
        if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 32'(m_valid), 32'(0));
            end else begin
                exp_d = sb.pop_front();
                check("m_data", 32'(m_data), 32'(exp_d));
            end
        end
        @(posedge clk);
        #1;
        check("rptr_step", 32'(binary_rptr == prev_rptr || binary_rptr == PW'(prev_rptr + 1'b1)), 32'(1));
        check("rptr_gray", 32'(rptr_gray), 32'(gray(binary_rptr)));
        check("rd_count_max", 32'(rd_count <= PW'(DEPTH)), 32'(1));
        if (prev_rptr == PW'(15) && binary_rptr == '0) wraps++;
        prev_rptr = binary_rptr;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_ae", 32'(almost_empty), 32'(1));
        check("rst_valid", 32'(m_valid), 32'(0));
        check("rst_count", 32'(rd_count), 32'(0));
        check("rst_rptr", 32'(binary_rptr), 32'(0));
        check("rst_gray", 32'(rptr_gray), 32'(0));
        check("rst_data", 32'(m_data), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Single word latency
        m_ready = 1'b1;
        write_word(8'hA5);
        step();
        step();
        check("single_empty_e2", 32'(empty), 32'(1));
        step();
        check("single_empty_e3", 32'(empty), 32'(0));
        check("single_valid_e3", 32'(m_valid), 32'(0));
        step();
        check("single_valid_e4", 32'(m_valid), 32'(1));
        check("single_data", 32'(m_data), 32'(8'hA5));
        check("single_rptr", 32'(binary_rptr), 32'(1));
        check("single_gray", 32'(rptr_gray), 32'(1));
        check("single_empty_e4", 32'(empty), 32'(1));
        step();
        check("single_drained", 32'(m_valid), 32'(0));

        // Backpressure
        m_ready = 1'b0;
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        repeat (5) step();
        check("bp_valid", 32'(m_valid), 32'(1));
        check("bp_data", 32'(m_data), 32'(8'h11));
        check("bp_count", 32'(rd_count), 32'(2));
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_data", 32'(m_data), 32'(8'h11));
            check("bp_hold_ren", 32'(r_en), 32'(0));
        end
        m_ready = 1'b1;
        repeat (4) step();
        check("bp_done_valid", 32'(m_valid), 32'(0));
        check("bp_done_empty", 32'(empty), 32'(1));
        check("bp_done_sb", 32'(sb.size()), 32'(0));

        // Almost-empty threshold
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) write_word(8'(8'h40 + i));
        repeat (6) step();
        check("ae_count5", 32'(rd_count), 32'(5));
        check("ae_flag5", 32'(almost_empty), 32'(0));
        check("ae_valid", 32'(m_valid), 32'(1));
        m_ready = 1'b1;
        for (int c = 4; c >= 2; c--) begin
            step();
            check("ae_count", 32'(rd_count), 32'(c));
            check("ae_flag", 32'(almost_empty), 32'(c <= AE));
        end
        repeat (4) step();
        check("ae_done_valid", 32'(m_valid), 32'(0));

        // Full FIFO: rd_count = DEPTH, distinguished from empty by the lap bit
        m_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (PW'(wbin - binary_rptr) < PW'(DEPTH)) write_word(8'(8'h80 + k));
            step();
        end
        check("full_count", 32'(rd_count), 32'(DEPTH));
        check("full_empty", 32'(empty), 32'(0));
        check("full_ae", 32'(almost_empty), 32'(0));
        check("full_valid", 32'(m_valid), 32'(1));
        m_ready = 1'b1;
        repeat (12) step();
        check("full_drain_empty", 32'(empty), 32'(1));
        check("full_drain_sb", 32'(sb.size()), 32'(0));

        // Streaming with wrap-around
        sent = 0;
        wraps = 0;
        for (int k = 0; k < 400 && (sent < 40 || sb.size() != 0); k++) begin
            if (sent < 40 && PW'(wbin - binary_rptr) < PW'(DEPTH)) begin
                write_word(8'(sent));
                sent++;
            end
            step();
        end
        check("stream_sent", 32'(sent), 32'(40));
        check("stream_sb", 32'(sb.size()), 32'(0));
        check("stream_wraps", 32'(wraps >= 2), 32'(1));

        // Reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) write_word(8'(8'hC0 + i));
        repeat (6) step();
        check("mid_valid", 32'(m_valid), 32'(1));
        check("mid_count", 32'(rd_count), 32'(4));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(m_valid), 32'(0));
        check("mid_rst_rptr", 32'(binary_rptr), 32'(0));
        check("mid_rst_empty", 32'(empty), 32'(1));
        check("mid_rst_count", 32'(rd_count), 32'(0));
        check("mid_rst_data", 32'(m_data), 32'(0));
        sb.delete();
        wbin = '0;
        wptr_gray_async = '0;
        prev_rptr = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_ready = 1'b1;
        repeat (6) begin
            step();
            check("post_rst_ren", 32'(r_en), 32'(0));
            check("post_rst_valid", 32'(m_valid), 32'(0));
            check("post_rst_empty", 32'(empty), 32'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
